// File: rtl/sram_2_16_sky130a_ctrl.sv
// Host-side initiator for the single-port RW SRAM macro: request/response handshakes
// mapped onto registered macro-port cycles, plus a whole-array clear sequencer.
module sram_2_16_sky130a_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    // state  | meaning
    // IDLE   | waiting for init_start or a request; req_ready high
    // ACCESS | macro port driven for one cycle (read or write)
    // RDWAIT | macro deselected; dout0 sampled at the closing edge
    // RESP   | rsp_valid held until the host takes the data
    // INIT   | writing CLEAR_VAL to every address in turn
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ACCESS = 3'd1;
    localparam logic [2:0] RDWAIT = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] INIT   = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] init_cnt;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            init_busy <= 1'b0;
            init_cnt  <= '0;
            csb0      <= 1'b1;
            web0      <= 1'b1;
            addr0     <= '0;
            din0      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is held low through reset; the first edge after release raises it
                    if (!req_ready) begin
                        req_ready <= 1'b1;
                    end else if (init_start) begin
                        state     <= INIT;
                        req_ready <= 1'b0;
                        init_busy <= 1'b1;
                        init_cnt  <= '0;
                        csb0      <= 1'b0;
                        web0      <= 1'b0;
                        addr0     <= '0;
                        din0      <= CLEAR_VAL;
                    end else if (req_valid) begin
                        state     <= ACCESS;
                        req_ready <= 1'b0;
                        csb0      <= 1'b0;
                        web0      <= ~req_we;
                        addr0     <= req_addr;
                        din0      <= req_wdata;
                    end
                end
                ACCESS: begin
                    csb0 <= 1'b1;
                    web0 <= 1'b1;
                    if (!web0) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rsp_rdata <= dout0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == LAST_ADDR) begin
                        state     <= IDLE;
                        csb0      <= 1'b1;
                        web0      <= 1'b1;
                        init_busy <= 1'b0;
                        req_ready <= 1'b1;
                    end else begin
                        addr0 <= init_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                    init_busy <= 1'b0;
                    csb0      <= 1'b1;
                    web0      <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_2_16_sky130a_ctrl.sv
// Bench for sram_2_16_sky130a_ctrl: behavioural macro, array reference model,
// vector table, hand-written corner sequences and a randomized traffic phase.
module tb_sram_2_16_sky130a_ctrl;

    logic       clk0 = 1'b0;
    logic       rst0 = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [3:0] req_addr = '0;
    logic [1:0] req_wdata = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b1;
    logic [1:0] rsp_rdata;
    logic       init_start = 1'b0;
    logic       init_busy;
    logic       csb0;
    logic       web0;
    logic [3:0] addr0;
    logic [1:0] din0;
    logic [1:0] dout0 = '0;

    int checks = 0;
    int errors = 0;

    logic [1:0] mac_mem [16];
    logic [1:0] ref_mem [16];

    sram_2_16_sky130a_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .CLEAR_VAL(2'b00)) dut (
        .clk0(clk0), .rst0(rst0),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_start(init_start), .init_busy(init_busy),
        .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0)
    );

    always #5 clk0 = ~clk0;

    // Macro model: captures at the rising edge, read data appears 2 time units later and holds.
    initial begin
        for (int i = 0; i < 16; i++) mac_mem[i] = 2'($urandom);
    end

    always @(posedge clk0) begin
        logic [1:0] rd;
        if (!csb0) begin
            if (!web0) begin
                mac_mem[addr0] = din0;
            end else begin
                rd = mac_mem[addr0];
                #2 dout0 = rd;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("ready_timeout", req_ready, 1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [1:0] d);
        wait_ready();
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
        chk("wr_csb", csb0, 0);
        chk("wr_web", web0, 0);
        chk("wr_addr", addr0, a);
        chk("wr_din", din0, d);
        tick();
        chk("wr_ready_again", req_ready, 1);
        chk("wr_csb_off", csb0, 1);
        ref_mem[a] = d;
    endtask

    task automatic do_read(input logic [3:0] a, input int stall, output logic [1:0] data);
        wait_ready();
        rsp_ready = (stall == 0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 2'($urandom);
        tick();
        req_valid = 1'b0;
        chk("rd_csb", csb0, 0);
        chk("rd_web", web0, 1);
        chk("rd_addr", addr0, a);
        tick();
        chk("rd_wait_valid", rsp_valid, 0);
        chk("rd_wait_csb", csb0, 1);
        tick();
        chk("rd_valid_latency", rsp_valid, 1);
        data = rsp_rdata;
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("rsp_hold_valid", rsp_valid, 1);
            chk("rsp_hold_data", rsp_rdata, data);
            chk("rsp_hold_req_ready", req_ready, 0);
            chk("rsp_hold_csb", csb0, 1);
        end
        rsp_ready = 1'b1;
        tick();
        chk("rsp_drop", rsp_valid, 0);
        chk("rsp_idle_ready", req_ready, 1);
    endtask

    task automatic do_init();
        wait_ready();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("init_csb", csb0, 0);
            chk("init_web", web0, 0);
            chk("init_addr", addr0, i);
            chk("init_din", din0, 0);
            chk("init_busy", init_busy, 1);
            tick();
        end
        chk("init_done_csb", csb0, 1);
        chk("init_done_busy", init_busy, 0);
        chk("init_done_ready", req_ready, 1);
        for (int i = 0; i < 16; i++) ref_mem[i] = 2'b00;
    endtask

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [1:0] wdata;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [1:0] rd;
        int n;

        vecs[0] = '{1'b1, 4'h3, 2'b10, 2'b00};
        vecs[1] = '{1'b0, 4'h3, 2'b00, 2'b10};
        vecs[2] = '{1'b1, 4'h0, 2'b01, 2'b00};
        vecs[3] = '{1'b1, 4'hF, 2'b11, 2'b00};
        vecs[4] = '{1'b0, 4'h0, 2'b00, 2'b01};
        vecs[5] = '{1'b0, 4'hF, 2'b00, 2'b11};
        vecs[6] = '{1'b1, 4'h3, 2'b01, 2'b00};
        vecs[7] = '{1'b0, 4'h3, 2'b00, 2'b01};
        vecs[8] = '{1'b1, 4'h3, 2'b10, 2'b00};
        vecs[9] = '{1'b0, 4'h3, 2'b00, 2'b10};

        // Power-on reset
        tick(); tick();
        chk("rst_csb", csb0, 1);
        chk("rst_web", web0, 1);
        chk("rst_addr", addr0, 0);
        chk("rst_din", din0, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_init_busy", init_busy, 0);
        chk("rst_req_ready", req_ready, 0);
        rst0 = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);

        // Reset for two cycles while a read sits in RDWAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'h2;
        tick();
        req_valid = 1'b0;
        tick();
        rst0 = 1'b1;
        tick();
        chk("midrd_rst_csb", csb0, 1);
        chk("midrd_rst_rsp_valid", rsp_valid, 0);
        tick();
        chk("midrd_rst_csb2", csb0, 1);
        chk("midrd_rst_rsp_valid2", rsp_valid, 0);
        chk("midrd_rst_init_busy", init_busy, 0);
        chk("midrd_rst_ready", req_ready, 0);
        rst0 = 1'b0;
        tick();
        chk("midrd_release_ready", req_ready, 1);
        chk("midrd_release_rsp_valid", rsp_valid, 0);

        // Vector table
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) begin
                do_write(vecs[i].addr, vecs[i].wdata);
            end else begin
                do_read(vecs[i].addr, 0, rd);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
        end

        // Read held off by the host for five cycles
        do_read(4'h3, 5, rd);
        chk("stall_rdata", rd, 2'b10);

        // Full clear, then the two end addresses
        do_init();
        do_read(4'h0, 0, rd);
        chk("clr_rd0", rd, 2'b00);
        do_read(4'hF, 0, rd);
        chk("clr_rdF", rd, 2'b00);

        // init_start and a write request in the same IDLE cycle
        wait_ready();
        init_start = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 2'b01;
        tick();
        init_start = 1'b0;
        chk("prio_init_busy", init_busy, 1);
        chk("prio_web", web0, 0);
        chk("prio_addr", addr0, 0);
        chk("prio_din", din0, 0);
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("prio_busy_len", n, 16);
        chk("prio_ready_after_init", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("prio_wr_csb", csb0, 0);
        chk("prio_wr_web", web0, 0);
        chk("prio_wr_addr", addr0, 4'h5);
        chk("prio_wr_din", din0, 2'b01);
        tick();
        for (int i = 0; i < 16; i++) ref_mem[i] = 2'b00;
        ref_mem[5] = 2'b01;
        do_read(4'h5, 0, rd);
        chk("prio_rd5", rd, 2'b01);

        // Preload 2'b11, abort init by reset when addr0 reaches 7
        for (int i = 0; i < 16; i++) do_write(4'(i), 2'b11);
        wait_ready();
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        n = 0;
        while (addr0 !== 4'h7 && n < 40) begin
            tick();
            n++;
        end
        chk("abort_reach7", n, 7);
        rst0 = 1'b1;
        tick();
        chk("abort_csb", csb0, 1);
        chk("abort_busy", init_busy, 0);
        chk("abort_ready", req_ready, 0);
        rst0 = 1'b0;
        tick();
        chk("abort_release_ready", req_ready, 1);
        chk("abort_release_csb", csb0, 1);
        // The reset edge itself still closes the addr0=7 write cycle.
        for (int i = 0; i < 8; i++) ref_mem[i] = 2'b00;
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 0, rd);
            chk($sformatf("abort_rd%0d", i), rd, ref_mem[i]);
        end

        // Randomized traffic against the reference array
        for (int t = 0; t < 80; t++) begin
            int op;
            logic [3:0] a;
            logic [1:0] d;
            op = $urandom_range(0, 19);
            a = 4'($urandom);
            d = 2'($urandom);
            if (op < 8) begin
                do_write(a, d);
            end else if (op < 19) begin
                do_read(a, $urandom_range(0, 3), rd);
                chk($sformatf("rand%0d_rdata", t), rd, ref_mem[a]);
            end else begin
                do_init();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
